// File: rtl/tour_pkg.sv
// Shared types and default constants for the tour counter.
package tour_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } tour_state_e;

    localparam int CNT_W_DEF    = 16;
    localparam int RPM_W_DEF    = 22;
    localparam int SCALE_DEF    = 60;
    localparam int DEBOUNCE_DEF = 4;

    function automatic int prod_width(input int cnt_w, input int scale);
        return cnt_w + $clog2(scale + 1);
    endfunction

endpackage

// File: rtl/sensor_filter.sv
// Two-flop synchroniser followed by a run-length debouncer.
module sensor_filter
    import tour_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic Clkin,
    input  logic Reset,
    input  logic Din,
    output logic Dout,
    output logic Rise
);

    logic [1:0] sync_q;
    logic       filt_q;
    logic       filt_d;
    logic [7:0] run_q;
    logic [7:0] run_d;
    logic       rise_q;

    // Level flips on the DEBOUNCE-th consecutive disagreeing cycle.
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (int'(run_q) + 1 >= DEBOUNCE) begin
                filt_d = sync_q[1];
            end else begin
                run_d = run_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clkin) begin
        if (Reset) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            run_q  <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], Din};
            filt_q <= filt_d;
            run_q  <= run_d;
            rise_q <= filt_d & ~filt_q;
        end
    end

    assign Dout = filt_q;
    assign Rise = rise_q;

endmodule

// File: rtl/tour_counter.sv
// Windowed rotation counter: edges per Gate period, scaled to tours/minute.
module tour_counter
    import tour_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int RPM_W    = RPM_W_DEF,
    parameter int SCALE    = SCALE_DEF,
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic             Clkin,
    input  logic             Reset,
    input  logic             Gate,
    input  logic             Sensor,
    output logic [CNT_W-1:0] Count,
    output logic [RPM_W-1:0] Rpm,
    output logic             Valid,
    output logic             Overflow
);

    localparam int PROD_W = prod_width(CNT_W, SCALE);
    localparam int MUL_W  = (PROD_W > RPM_W) ? PROD_W : RPM_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [MUL_W-1:0] RPM_MAX = MUL_W'({RPM_W{1'b1}});

    tour_state_e      state_q;
    tour_state_e      state_d;
    logic             gate_q;
    logic             gate_rise;
    logic             filt_lvl;
    logic             filt_rise;
    logic             sens_edge;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sat_q;
    logic             sat_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [RPM_W-1:0] rpm_q;
    logic [RPM_W-1:0] rpm_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             valid_q;
    logic             valid_d;
    logic [MUL_W-1:0] prod;
    logic [RPM_W-1:0] rpm_sat;

    sensor_filter #(
        .DEBOUNCE(DEBOUNCE)
    ) u_filter (
        .Clkin(Clkin),
        .Reset(Reset),
        .Din  (Sensor),
        .Dout (filt_lvl),
        .Rise (filt_rise)
    );

    assign gate_rise = Gate & ~gate_q;
    assign sens_edge = filt_rise & filt_lvl;

    assign prod    = MUL_W'(cnt_q) * MUL_W'(SCALE);
    assign rpm_sat = (prod > RPM_MAX) ? {RPM_W{1'b1}}
                                      : prod[RPM_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        count_d = count_q;
        rpm_d   = rpm_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (gate_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (gate_rise) begin
                    count_d = cnt_q;
                    ovf_d   = sat_q;
                    rpm_d   = rpm_sat;
                    valid_d = 1'b1;
                    // A coincident edge belongs to the window just opening.
                    cnt_d   = sens_edge ? CNT_W'(1) : '0;
                    sat_d   = 1'b0;
                end else if (sens_edge) begin
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clkin) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            gate_q  <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            rpm_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= Gate;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            rpm_q   <= rpm_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign Count    = count_q;
    assign Rpm      = rpm_q;
    assign Valid    = valid_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_tour_counter.sv
// Directed windows plus randomized traffic against a sample-window reference model.
module tb_tour_counter;

    localparam int  DEB     = 4;
    localparam int  SC      = 60;
    localparam longint RMAX = 64'd4194303;

    typedef struct {
        int pulses;
        int hi;
        int lo;
        int c16;
        int c4;
        int o4;
    } vec_t;

    logic        Clkin;
    logic        Reset;
    logic        Gate;
    logic        Sensor;
    logic [15:0] Count16;
    logic [21:0] Rpm16;
    logic        Valid16;
    logic        Ovf16;
    logic [3:0]  Count4;
    logic [21:0] Rpm4;
    logic        Valid4;
    logic        Ovf4;

    int total = 0;
    int bad   = 0;
    int nv16  = 0;
    int nv4   = 0;
    bit chk_en = 0;

    tour_counter dut16 (
        .Clkin   (Clkin),
        .Reset   (Reset),
        .Gate    (Gate),
        .Sensor  (Sensor),
        .Count   (Count16),
        .Rpm     (Rpm16),
        .Valid   (Valid16),
        .Overflow(Ovf16)
    );

    tour_counter #(.CNT_W(4)) dut4 (
        .Clkin   (Clkin),
        .Reset   (Reset),
        .Gate    (Gate),
        .Sensor  (Sensor),
        .Count   (Count4),
        .Rpm     (Rpm4),
        .Valid   (Valid4),
        .Overflow(Ovf4)
    );

    initial begin
        Clkin = 0;
        forever #5 Clkin = ~Clkin;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: filter flips once the last DEB synced samples all
    // disagree with it; synced sample = Sensor two clocks earlier.
    bit     sq[$];
    bit     m_filt, m_rise, m_gate, m_armed, m_gr, m_diff;
    int     m_cnt[2];
    bit     m_sat[2];
    int     m_max[2] = '{65535, 15};
    int     e_cnt[2];
    bit     e_ovf[2];
    bit     e_val[2];
    longint e_rpm[2];

    always @(posedge Clkin) begin
        if (Reset) begin
            sq.delete();
            repeat (DEB + 2) sq.push_front(1'b0);
            m_filt = 0; m_rise = 0; m_gate = 0; m_armed = 0;
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0; m_sat[k] = 0;
                e_cnt[k] = 0; e_ovf[k] = 0; e_val[k] = 0; e_rpm[k] = 0;
            end
        end else begin
            m_gr   = Gate && !m_gate;
            m_gate = Gate;
            for (int k = 0; k < 2; k++) begin
                e_val[k] = 0;
                if (!m_armed) begin
                    if (m_gr) begin
                        m_cnt[k] = 0; m_sat[k] = 0;
                    end
                end else if (m_gr) begin
                    longint p;
                    p = longint'(m_cnt[k]) * SC;
                    e_cnt[k] = m_cnt[k];
                    e_ovf[k] = m_sat[k];
                    e_rpm[k] = (p > RMAX) ? RMAX : p;
                    e_val[k] = 1;
                    m_cnt[k] = m_rise ? 1 : 0;
                    m_sat[k] = 0;
                end else if (m_rise) begin
                    if (m_cnt[k] == m_max[k]) m_sat[k] = 1;
                    else m_cnt[k]++;
                end
            end
            if (m_gr) m_armed = 1;
            sq.push_front(Sensor);
            m_diff = 1;
            for (int i = 2; i < DEB + 2; i++)
                if (sq[i] == m_filt) m_diff = 0;
            void'(sq.pop_back());
            m_rise = 0;
            if (m_diff) begin
                m_filt = !m_filt;
                m_rise = m_filt;
            end
        end
    end

    always @(negedge Clkin) begin
        if (Valid16 === 1'b1) nv16++;
        if (Valid4 === 1'b1) nv4++;
        if (chk_en) begin
            chk("m_count16", 64'(Count16), 64'(e_cnt[0]));
            chk("m_rpm16",   64'(Rpm16),   64'(e_rpm[0]));
            chk("m_valid16", 64'(Valid16), 64'(e_val[0]));
            chk("m_ovf16",   64'(Ovf16),   64'(e_ovf[0]));
            chk("m_count4",  64'(Count4),  64'(e_cnt[1]));
            chk("m_rpm4",    64'(Rpm4),    64'(e_rpm[1]));
            chk("m_valid4",  64'(Valid4),  64'(e_val[1]));
            chk("m_ovf4",    64'(Ovf4),    64'(e_ovf[1]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clkin);
    endtask

    task automatic gate_pulse(input int hold);
        Gate = 1;
        tick(hold);
        Gate = 0;
        tick(2);
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        repeat (n) begin
            Sensor = 1;
            tick(hi);
            Sensor = 0;
            tick(lo);
        end
    endtask

    task automatic do_reset();
        Reset = 1;
        tick(2);
        Reset = 0;
        tick(1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_count16"}, 64'(Count16), 0);
        chk({nm, "_rpm16"},   64'(Rpm16),   0);
        chk({nm, "_valid16"}, 64'(Valid16), 0);
        chk({nm, "_ovf16"},   64'(Ovf16),   0);
        chk({nm, "_count4"},  64'(Count4),  0);
        chk({nm, "_ovf4"},    64'(Ovf4),    0);
    endtask

    vec_t vt[4];
    int   n0;
    int   n1;

    initial begin
        Reset = 1; Gate = 0; Sensor = 0;
        vt[0] = '{7, 10, 10, 7, 7, 0};
        vt[1] = '{4, 3, 10, 0, 0, 0};
        vt[2] = '{20, 5, 5, 20, 15, 1};
        vt[3] = '{2, 10, 10, 2, 2, 0};

        do_reset();
        chk_en = 1;
        chk_zero("reset");

        n0 = nv16;
        gate_pulse(1);
        chk("arm_no_valid", 64'(nv16 - n0), 0);

        foreach (vt[i]) begin
            n0 = nv16; n1 = nv4;
            pulses(vt[i].pulses, vt[i].hi, vt[i].lo);
            tick(10);
            gate_pulse(1);
            chk($sformatf("row%0d_nvalid16", i), 64'(nv16 - n0), 1);
            chk($sformatf("row%0d_nvalid4", i), 64'(nv4 - n1), 1);
            chk($sformatf("row%0d_count16", i), 64'(Count16), 64'(vt[i].c16));
            chk($sformatf("row%0d_rpm16", i), 64'(Rpm16), 64'(vt[i].c16 * 60));
            chk($sformatf("row%0d_ovf16", i), 64'(Ovf16), 0);
            chk($sformatf("row%0d_count4", i), 64'(Count4), 64'(vt[i].c4));
            chk($sformatf("row%0d_rpm4", i), 64'(Rpm4), 64'(vt[i].c4 * 60));
            chk($sformatf("row%0d_ovf4", i), 64'(Ovf4), 64'(vt[i].o4));
        end

        // Filtered rise lands on the gate_rise cycle.
        pulses(3, 10, 10);
        tick(10);
        Sensor = 1;
        tick(6);
        Gate = 1;
        tick(1);
        Gate = 0;
        chk("coinc_valid", 64'(Valid16), 1);
        chk("coinc_close", 64'(Count16), 3);
        tick(3);
        Sensor = 0;
        tick(10);
        pulses(1, 10, 10);
        tick(10);
        gate_pulse(1);
        chk("coinc_next", 64'(Count16), 2);

        // Pulses before the first gate after reset are discarded.
        do_reset();
        pulses(3, 10, 10);
        n0 = nv16;
        gate_pulse(1);
        chk("pre_no_valid", 64'(nv16 - n0), 0);
        chk("pre_count", 64'(Count16), 0);
        pulses(2, 10, 10);
        tick(10);
        n0 = nv16;
        gate_pulse(1);
        chk("pre_next_valid", 64'(nv16 - n0), 1);
        chk("pre_next_count", 64'(Count16), 2);

        // Reset in the middle of a window.
        pulses(5, 10, 10);
        tick(10);
        gate_pulse(1);
        chk("mid_prev_count", 64'(Count16), 5);
        pulses(5, 10, 10);
        do_reset();
        chk_zero("mid_reset");
        n0 = nv16;
        gate_pulse(1);
        chk("mid_arm_no_valid", 64'(nv16 - n0), 0);
        pulses(2, 10, 10);
        tick(10);
        n0 = nv16;
        gate_pulse(1);
        chk("mid_second_valid", 64'(nv16 - n0), 1);
        chk("mid_second_count", 64'(Count16), 2);

        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60) begin
                pulses(1, $urandom_range(1, 8), $urandom_range(1, 8));
            end else if (r < 85) begin
                gate_pulse($urandom_range(1, 4));
            end else if (r < 88) begin
                Reset = 1;
                tick($urandom_range(1, 2));
                Reset = 0;
            end else begin
                tick($urandom_range(1, 20));
            end
        end
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tour_counter.md
TOUR_COUNTER -- requirements
Module: tour_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the per-window sensor edge count.
REQ-002 SHALL have parameter RPM_W, default 22, width of the scaled speed output.
REQ-003 SHALL have parameter SCALE, default 60, multiplier from edges-per-window to tours-per-minute (1 s window).
REQ-004 SHALL have parameter DEBOUNCE, default 4, consecutive stable cycles needed to accept a sensor level change (range 1..255).
REQ-005 SHALL have port Clkin  input  1  system clock, all logic on its rising edge.
REQ-006 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port Gate  input  1  measurement window clock from the frequency divider, same clock domain; each rising edge is a window boundary.
REQ-008 SHALL have port Sensor  input  1  asynchronous rotation sensor, one rising edge per tour.
REQ-009 SHALL have port Count  output  CNT_W  edges counted in the last completed window.
REQ-010 SHALL have port Rpm  output  RPM_W  Count*SCALE, saturated to 2^RPM_W-1.
REQ-011 SHALL have port Valid  output  1  one-cycle pulse when Count/Rpm/Overflow update.
REQ-012 SHALL have port Overflow  output  1  last completed window's counter saturated.

Function
REQ-013 Sensor SHALL pass a 2-flop synchroniser, then a debouncer whose filtered level follows the synced level only after DEBOUNCE consecutive cycles of disagreement; any agreeing cycle restarts the run.
REQ-014 A sensor edge SHALL be one cycle where the filtered level goes 0->1; filtered 1->0 is ignored.
REQ-015 Gate SHALL be registered once; gate_rise = Gate & ~Gate_q.
REQ-016 FSM SHALL have states IDLE and MEASURE; reset enters IDLE.
REQ-017 IDLE: sensor edges ignored; on gate_rise -> MEASURE with internal counter cleared, no Valid (partial first window discarded).
REQ-018 MEASURE: each sensor edge increments the internal counter, saturating at 2^CNT_W-1 and setting an internal sat flag.
REQ-019 MEASURE on gate_rise: Count<=counter, Overflow<=sat flag, Rpm<=saturated counter*SCALE, Valid=1 next cycle only; counter and sat flag restart.
REQ-020 Sensor edge in the same cycle as gate_rise SHALL count in the new window (new counter = 1), not the closing one.
REQ-021 Outputs SHALL hold their values between Valid pulses.
REQ-022 Product SHALL be computed at width CNT_W+ceil(log2(SCALE+1)) before saturation to RPM_W.
REQ-023 Gate held constant: no Valid, counter keeps accumulating/saturating.

Reset
REQ-024 Reset SHALL clear synchroniser, debouncer (filtered level 0, run count 0), Gate_q (0), counter, sat flag, state to IDLE.
REQ-025 Reset values SHALL be Count=0, Rpm=0, Valid=0, Overflow=0.
REQ-026 Reset asserted mid-window SHALL discard that window; after release the first gate_rise only arms MEASURE.

Structure
REQ-027 FSM state encoding and default parameter constants SHALL live in shared package tour_pkg.
REQ-028 Synchroniser+debouncer SHALL be sub-module sensor_filter (ports Clkin, Reset, Din, Dout, Rise), instantiated once.
REQ-029 No clock gating or use of Gate as a clock; Gate is data only.

Verification
REQ-030 Reset, Gate rise at t0, 7 clean sensor pulses (each 10 cycles high/10 low, DEBOUNCE=4), Gate rise at t1 -> one Valid, Count=7, Rpm=420, Overflow=0.
REQ-031 Sensor glitches of 3 cycles high with DEBOUNCE=4 during a window -> Count=0 at window end.
REQ-032 CNT_W=4, 20 pulses in one window -> Count=15, Overflow=1, Rpm=900; next window of 2 pulses -> Count=2, Overflow=0.
REQ-033 Filtered sensor rise coincident with gate_rise -> closing window excludes it, next Count includes it.
REQ-034 Pulses before the first Gate rise after reset -> no Valid at first Gate rise, Count stays 0.
REQ-035 Reset pulsed mid-window after 5 pulses -> all outputs 0, no Valid until two further Gate rises.
